// File: rtl/regfile_pkg.sv
// Shared types, default sizes and packed-port slicing helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // LSB position of port `port` inside a packed bus of `width`-bit fields.
    function automatic int unsigned rf_port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every entry writing zero after reset or on request.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_e         state_q,   state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        unique case (state_q)
            RF_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart mid-clear.
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RF_IDLE;
                    clr_idx_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    assign clr_we   = (state_q == RF_CLEAR);
    assign clr_addr = clr_idx_q;
    assign busy     = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD bypassed read ports, two write ports, optional zero reg, hardware clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_req,
    output logic                     busy
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr0_ok, wr1_ok;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // Effective write enables shared by the array update and the bypass network.
    assign wr0_ok = we0 && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (wa1 == '0));

    // Port 1 is applied last so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (rst_n) begin
            if (wr0_ok) mem_d[wa0] = wd0;
            if (wr1_ok) mem_d[wa1] = wd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;

        assign ra = rd_addr[rf_port_lsb(g, ADDR_W) +: ADDR_W];

        always_comb begin
            rdat = mem_q[ra];
            if (busy || (ZERO_REG && (ra == '0))) begin
                rdat = '0;
            end else if (wr1_ok && (wa1 == ra)) begin
                rdat = wd1;
            end else if (wr0_ok && (wa0 == ra)) begin
                rdat = wd0;
            end
        end

        assign rd_data[rf_port_lsb(g, DATA_W) +: DATA_W] = rdat;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-and-countdown reference model.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we0, we1, clr_req;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        busy;

    logic [31:0] regs [32];
    int          clr_left;
    int          n_vec;
    int          n_err;

    regfile_mp #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .clr_req (clr_req),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a clear is modelled as "array becomes zero, reads blanked for 32 cycles".
    task automatic model_edge();
        if (!rst_n) begin
            clr_left = 32;
            for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        end else if (clr_left > 0) begin
            clr_left = clr_left - 1;
        end else begin
            if (we0 && wa0 != 5'd0) regs[wa0] = wd0;
            if (we1 && wa1 != 5'd0) regs[wa1] = wd1;
            if (clr_req) begin
                clr_left = 32;
                for (int i = 0; i < 32; i++) regs[i] = 32'h0;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (clr_left > 0 || a == 5'd0) return 32'h0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return regs[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
        clr_req = 1'b0;
        rd_addr = 10'd0;
    endtask

    task automatic test_reset();
        int cnt;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== (clr_left > 0)) begin
                n_err++;
                $display("FAIL reset_busy cycle=%0d got=%b exp=%b", i, busy, clr_left > 0);
            end
            if (busy !== 1'b1) break;
            cnt++;
            tick();
        end
        tick();
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL reset_busy_len got=%0d exp=32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  ra;
                logic [31:0] g;
                ra = rd_addr[p*5 +: 5];
                g  = rd_data[p*32 +: 32];
                n_vec++;
                if (g !== 32'h0 || g !== exp_rd(ra)) begin
                    n_err++;
                    $display("FAIL reset_read port%0d addr=%0d got=%h exp=00000000", p, ra, g);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        n_vec++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== exp_rd(5'd5)) begin
            n_err++;
            $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd_data);
        end
        tick();
        we0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[31:0] !== exp_rd(5'd5)) begin
            n_err++;
            $display("FAIL bypass_stored got=%h exp=deadbeef", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_port_priority();
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        rd_addr = {5'd7, 5'd7};
        @(negedge clk);
        n_vec++;
        if (rd_data !== {32'h22, 32'h22}) begin
            n_err++;
            $display("FAIL prio_bypass got=%h exp=%h", rd_data, {32'h22, 32'h22});
        end
        tick();
        we0 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rd_data[31:0] !== 32'h22 || rd_data[31:0] !== exp_rd(5'd7)) begin
            n_err++;
            $display("FAIL prio_stored got=%h exp=00000022", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hA5A5A5A5;
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        n_vec++;
        if (rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL zero_bypass got=%h exp=0", rd_data);
        end
        tick();
        we0 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL zero_stored got=%h exp=0", rd_data);
        end
        tick();
    endtask

    task automatic test_clear_request();
        int cnt;
        idle_inputs();
        for (int r = 1; r <= 3; r++) begin
            we0 = 1'b1; wa0 = 5'(r); wd0 = 32'(r);
            tick();
        end
        we0 = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            rd_addr = {5'(r), 5'(r)};
            @(negedge clk);
            n_vec++;
            if (rd_data[31:0] !== 32'(r) || rd_data[63:32] !== exp_rd(5'(r))) begin
                n_err++;
                $display("FAIL clr_preload addr=%0d got=%h exp=%h", r, rd_data, {32'(r), 32'(r)});
            end
            tick();
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom); wd1 = $urandom;
            clr_req = (i == 10);
            rd_addr = 10'($urandom);
            @(negedge clk);
            n_vec++;
            if (busy !== (clr_left > 0)) begin
                n_err++;
                $display("FAIL clr_busy cycle=%0d got=%b exp=%b", i, busy, clr_left > 0);
            end
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  ra;
                logic [31:0] g, e;
                ra = rd_addr[p*5 +: 5];
                g  = rd_data[p*32 +: 32];
                e  = exp_rd(ra);
                n_vec++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL clr_read cycle=%0d port%0d addr=%0d got=%h exp=%h", i, p, ra, g, e);
                end
            end
            if (busy !== 1'b1) break;
            cnt++;
            tick();
        end
        idle_inputs();
        tick();
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL clr_busy_len got=%0d exp=32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            @(negedge clk);
            n_vec++;
            if (rd_data !== 64'h0) begin
                n_err++;
                $display("FAIL clr_after addr=%0d got=%h exp=0", a, rd_data);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        tick();
        we0 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== (clr_left > 0)) begin
                n_err++;
                $display("FAIL rstmid_busy cycle=%0d got=%b exp=%b", i, busy, clr_left > 0);
            end
            if (busy !== 1'b1) break;
            cnt++;
            tick();
        end
        tick();
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL rstmid_busy_len got=%0d exp=32", cnt);
        end
        rd_addr = {5'd31, 5'd9};
        @(negedge clk);
        n_vec++;
        if (rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL rstmid_read got=%h exp=0", rd_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom); wd1 = $urandom;
            if ($urandom_range(0, 3) == 0) wa1 = wa0;
            clr_req = ($urandom_range(0, 99) == 0);
            rd_addr = 10'($urandom);
            if ($urandom_range(0, 2) == 0) rd_addr[4:0] = wa1;
            @(negedge clk);
            n_vec++;
            if (busy !== (clr_left > 0)) begin
                n_err++;
                $display("FAIL rand_busy cycle=%0d got=%b exp=%b", i, busy, clr_left > 0);
            end
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  ra;
                logic [31:0] g, e;
                ra = rd_addr[p*5 +: 5];
                g  = rd_data[p*32 +: 32];
                e  = exp_rd(ra);
                n_vec++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL rand_read cycle=%0d port%0d addr=%0d got=%h exp=%h", i, p, ra, g, e);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_left = 32;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_port_priority();
        test_zero_reg();
        test_clear_request();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
